noc_crc_master: RTL and testbench
=================================

Name: noc_crc_master

Overview:
- Bus-master stage directly upstream of the CRC slave. Accepts byte-serial NOC command packets and converts each into one register access on the CRC register bus (RW/Sel/addr/data_wr/data_rd).
- Returns read data, and optionally write acknowledgements, as byte-serial NOC response packets.
- Provides exactly one outstanding transaction, with valid/ready handshakes on both NOC sides.

Parameters:
- BASE_ADDR, 32'h4003_2000: CRC register base. A register index idx maps to BASE_ADDR + 4*idx.
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- rx_data  in  8  NOC command byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  block accepts rx byte
- tx_data  out  8  NOC response byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  downstream accepts tx byte
- bus_addr  out  32  register address to CRC
- bus_data_wr  out  32  write data to CRC
- bus_RW  out  1  1=write, 0=read; high only while bus_Sel=1
- bus_Sel  out  1  access strobe, exactly one cycle per access
- bus_data_rd  in  32  combinational read data from CRC (function of bus_addr)
- err_cnt  out  ERR_W  count of invalid-index packets, saturating
- busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Byte transfer: a byte moves when valid && ready at the clk rising edge.
  - rx_data is sampled only on an rx handshake.
  - Gaps (valid low) between bytes are allowed on both sides.
- Command header byte:
  - bit7: wr (1=write, 0=read)
  - bits[6:2]: src_id
  - bits[1:0]: idx (0=data, 1=gpoly, 2=ctrl, 3=invalid)
  - Write packets carry 4 payload bytes, MSB first. Read packets carry no payload.
- FSM states: IDLE, PAYLOAD, BUS, RESP_HDR, RESP_DATA.
- IDLE:
  - rx_ready=1.
  - On a header handshake, latch wr, src_id and idx.
  - wr=1 goes to PAYLOAD with byte count 0. wr=0 goes to BUS.
- PAYLOAD:
  - rx_ready=1.
  - Shift each accepted byte into a 32-bit holding register, MSB first.
  - After the 4th byte handshake, go to BUS.
- BUS (exactly one cycle):
  - idx≠3: bus_Sel=1, bus_addr=BASE_ADDR+4*idx, bus_RW=wr, bus_data_wr=holding register.
  - Read: capture bus_data_rd at the end of this cycle.
  - idx=3: no access (bus_Sel stays 0); err_cnt increments and saturates at all-ones.
  - Next state: RESP_HDR if the access was a read, or if it was a write and NOC_WR_ACK_EN is defined; otherwise IDLE.
- Response header: {1'b1, src_id, err, kind}.
  - err=1 when idx=3.
  - kind=0 for read data, 1 for write ack.
- RESP_HDR:
  - tx_valid=1 carrying the header.
  - On handshake, go to RESP_DATA for reads, IDLE for acks.
- RESP_DATA:
  - Send the 4 captured bytes, MSB first.
  - If idx=3, the data is 32'h0000_0000.
  - After the 4th handshake, go to IDLE.
- Output stability:
  - While tx_valid=1 and tx_ready=0, tx_data holds stable and tx_valid does not drop.
  - rx_ready=0 in BUS, RESP_HDR and RESP_DATA.
- Bus outputs between accesses:
  - bus_addr and bus_data_wr hold their last values.
  - bus_Sel=0 and bus_RW=0.
- Latency:
  - Write: Sel asserts 1 cycle after the 4th payload handshake.
  - Read: Sel asserts 1 cycle after the header handshake; response header tx_valid asserts on the following cycle.
- Reset (asynchronous, any state, including mid-packet or mid-response):
  - FSM goes to IDLE; the partial packet or response is discarded.
  - All outputs go to 0: tx_data, tx_valid, bus_*, err_cnt. busy=0.
  - rx_ready=1 once rst deasserts.
- Header values ignored: there are no reserved header bit values; every header is accepted.

Optional Feature:
- Macro: NOC_WR_ACK_EN.
- Defined: every write packet, including idx=3, produces a 1-byte response header with kind=1 and err as defined above.
- Undefined: writes produce no tx traffic and RESP_HDR is entered for reads only.

Test Plan:
- Write gpoly: rx 0x8D,0x04,0xC1,0x1D,0xB7.
  - One cycle of bus_Sel=1, bus_RW=1, bus_addr=0x4003_2004, bus_data_wr=0x04C1_1DB7.
  - No tx traffic without NOC_WR_ACK_EN; tx 0x8D with it.
- Read ctrl: rx 0x16 with bus_data_rd=0x2500_0000 at BUS.
  - One cycle of bus_Sel=1, bus_RW=0, bus_addr=0x4003_2008.
  - tx 0x94,0x25,0x00,0x00,0x00.
- Invalid read: rx 0x03.
  - No bus_Sel; err_cnt=1.
  - tx 0x82,0x00,0x00,0x00,0x00.
  - 255 further invalid packets leave err_cnt=0xFF.
- Backpressure: during a read response, hold tx_ready=0 for 5 cycles on each byte.
  - tx_valid stays 1, tx_data stays stable, rx_ready=0 throughout.
  - Full 5-byte response is delivered in order.
- Reset mid-packet: send 0x81,0xAA, pulse rst low, then send 0x80,0x11,0x22,0x33,0x44.
  - No access for the first packet.
  - Second packet writes 0x1122_3344 to 0x4003_2000.

Source files
------------

// File: rtl/noc_crc_master.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// noc_crc_master
//
// Bus-master stage in front of the CRC slave. Each byte-serial NOC command
// packet becomes exactly one register access on the CRC register bus. Read
// data, and optionally write acknowledgements, return as byte-serial NOC
// response packets. One transaction is in flight at a time.
//
// Command header : {wr, src_id[4:0], idx[1:0]}; writes carry 4 payload
//                  bytes MSB first, reads carry none. idx=3 is invalid.
// Response header: {1'b1, src_id[4:0], err, kind}; kind=0 read, 1 write ack.
//
// Optional feature macro: NOC_WR_ACK_EN
//   defined   -> every write (including idx=3) returns a 1-byte ack header
//   undefined -> writes produce no tx traffic
//
// Ports
//   clk          clock
//   rst          asynchronous reset, active-low
//   rx_data      NOC command byte
//   rx_valid     rx_data valid
//   rx_ready     block accepts an rx byte (IDLE and PAYLOAD only)
//   tx_data      NOC response byte
//   tx_valid     tx_data valid
//   tx_ready     downstream accepts the tx byte
//   bus_addr     register address (BASE_ADDR + 4*idx), holds between accesses
//   bus_data_wr  write data, holds between accesses
//   bus_RW       1=write, 0=read; only ever high together with bus_Sel
//   bus_Sel      access strobe, one cycle per access
//   bus_data_rd  combinational read data from the CRC slave
//   err_cnt      saturating count of invalid-index packets
//   busy         high whenever the FSM is not idle
// ---------------------------------------------------------------------------
module noc_crc_master #(
    parameter logic [31:0] BASE_ADDR = 32'h4003_2000,
    parameter int          ERR_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic [31:0]      bus_addr,
    output logic [31:0]      bus_data_wr,
    output logic             bus_RW,
    output logic             bus_Sel,
    input  logic [31:0]      bus_data_rd,
    output logic [ERR_W-1:0] err_cnt,
    output logic             busy
);

`ifdef NOC_WR_ACK_EN
    localparam logic WR_ACK = 1'b1;
`else
    localparam logic WR_ACK = 1'b0;
`endif

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_PAYLOAD   = 3'd1;
    localparam logic [2:0] S_BUS       = 3'd2;
    localparam logic [2:0] S_RESP_HDR  = 3'd3;
    localparam logic [2:0] S_RESP_DATA = 3'd4;

    localparam logic [1:0] IDX_INVALID = 2'd3;

    logic [2:0]  state;
    logic        wr_q;
    logic [4:0]  src_q;
    logic [1:0]  idx_q;
    logic [1:0]  byte_cnt;
    logic [31:0] hold;     // write payload being assembled
    logic [31:0] rdata;    // read data, shifted out MSB first

    logic        rx_hs;
    logic        tx_hs;
    logic [31:0] hold_next;

    assign rx_hs     = rx_valid && rx_ready;
    assign tx_hs     = tx_valid && tx_ready;
    assign hold_next = {hold[23:0], rx_data};

    function automatic logic [31:0] reg_addr(input logic [1:0] idx);
        return BASE_ADDR + {28'd0, idx, 2'b00};
    endfunction

    // The strobe is decoded straight from the state so it is high for the
    // single BUS cycle only; the address and data registers are loaded on
    // entry to BUS and simply hold afterwards.
    assign rx_ready = (state == S_IDLE) || (state == S_PAYLOAD);
    assign busy     = (state != S_IDLE);
    assign bus_Sel  = (state == S_BUS) && (idx_q != IDX_INVALID);
    assign bus_RW   = bus_Sel && wr_q;

    // NOTE: every register in this block, including the 32-bit holding and
    // read-data registers, is reset so that an aborted packet leaves nothing
    // behind; all assignments are non-blocking so each branch sees the values
    // from before the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            wr_q        <= 1'b0;
            src_q       <= '0;
            idx_q       <= '0;
            byte_cnt    <= '0;
            hold        <= '0;
            rdata       <= '0;
            tx_data     <= '0;
            tx_valid    <= 1'b0;
            bus_addr    <= '0;
            bus_data_wr <= '0;
            err_cnt     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (rx_hs) begin
                        wr_q     <= rx_data[7];
                        src_q    <= rx_data[6:2];
                        idx_q    <= rx_data[1:0];
                        byte_cnt <= '0;
                        if (rx_data[7]) begin
                            state <= S_PAYLOAD;
                        end else begin
                            state <= S_BUS;
                            if (rx_data[1:0] != IDX_INVALID) begin
                                bus_addr    <= reg_addr(rx_data[1:0]);
                                bus_data_wr <= hold;
                            end
                        end
                    end
                end

                S_PAYLOAD: begin
                    if (rx_hs) begin
                        hold     <= hold_next;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            state <= S_BUS;
                            if (idx_q != IDX_INVALID) begin
                                bus_addr    <= reg_addr(idx_q);
                                bus_data_wr <= hold_next;
                            end
                        end
                    end
                end

                S_BUS: begin
                    if (idx_q == IDX_INVALID) begin
                        rdata <= '0;
                        if (err_cnt != {ERR_W{1'b1}}) begin
                            err_cnt <= err_cnt + 1'b1;
                        end
                    end else begin
                        rdata <= bus_data_rd;
                    end
                    if (!wr_q || WR_ACK) begin
                        state    <= S_RESP_HDR;
                        tx_valid <= 1'b1;
                        tx_data  <= {1'b1, src_q, (idx_q == IDX_INVALID), wr_q};
                    end else begin
                        state <= S_IDLE;
                    end
                end

                S_RESP_HDR: begin
                    if (tx_hs) begin
                        if (wr_q) begin
                            tx_valid <= 1'b0;
                            state    <= S_IDLE;
                        end else begin
                            tx_data  <= rdata[31:24];
                            rdata    <= {rdata[23:0], 8'h00};
                            byte_cnt <= '0;
                            state    <= S_RESP_DATA;
                        end
                    end
                end

                S_RESP_DATA: begin
                    if (tx_hs) begin
                        if (byte_cnt == 2'd3) begin
                            tx_valid <= 1'b0;
                            state    <= S_IDLE;
                        end else begin
                            tx_data  <= rdata[31:24];
                            rdata    <= {rdata[23:0], 8'h00};
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_noc_crc_master.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_noc_crc_master
//
// Self-checking bench for noc_crc_master. A packet-level reference model
// (register array, saturating error count, expected tx byte stream and
// expected bus accesses) is updated per command packet; monitors collect what
// the DUT actually does on the bus and tx side. A small register-array slave
// answers bus reads. Honours NOC_WR_ACK_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_noc_crc_master;

    localparam logic [31:0] BASE = 32'h4003_2000;
`ifdef NOC_WR_ACK_EN
    localparam bit ACK = 1'b1;
`else
    localparam bit ACK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic [31:0] bus_addr;
    logic [31:0] bus_data_wr;
    logic        bus_RW;
    logic        bus_Sel;
    logic [31:0] bus_data_rd;
    logic [7:0]  err_cnt;
    logic        busy;

    always #5 clk = ~clk;

    noc_crc_master #(.BASE_ADDR(BASE), .ERR_W(8)) dut (
        .clk(clk), .rst(rst),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .bus_addr(bus_addr), .bus_data_wr(bus_data_wr),
        .bus_RW(bus_RW), .bus_Sel(bus_Sel), .bus_data_rd(bus_data_rd),
        .err_cnt(err_cnt), .busy(busy)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic        rw;
        logic [31:0] data;
    } acc_t;

    int errors = 0;
    int checks = 0;

    // ---------------- CRC slave stand-in and monitors ----------------
    logic [31:0] slave_regs [0:3] = '{default: 32'h0};
    logic [31:0] rd_off;
    acc_t        acc_q[$];
    logic [7:0]  tx_q[$];
    int          rw_glitch = 0;

    always_comb begin
        rd_off      = bus_addr - BASE;
        bus_data_rd = 32'hDEAD_BEEF;
        if (rd_off < 32'd12) bus_data_rd = slave_regs[rd_off[3:2]];
    end

    always @(negedge clk) begin
        if (bus_RW && !bus_Sel) rw_glitch <= rw_glitch + 1;
        if (bus_Sel) begin
            acc_q.push_back({bus_addr, bus_RW, bus_data_wr});
            if (bus_RW) slave_regs[2'((bus_addr - BASE) >> 2)] <= bus_data_wr;
        end
        // inputs only change at #1 after posedge, so this predicts the
        // handshake at the coming rising edge
        if (tx_valid && tx_ready) tx_q.push_back(tx_data);
    end

    // tx_ready modes: 0 always ready, 1 random, 2 five stall cycles per byte,
    // 3 never ready
    int rdy_mode = 0;
    always @(posedge clk) begin
        static int stall = 0;
        #1;
        case (rdy_mode)
            0: tx_ready = 1'b1;
            1: tx_ready = 1'($urandom_range(0, 1));
            2: begin
                if (tx_valid && stall < 5) begin
                    tx_ready = 1'b0;
                    stall++;
                end else begin
                    tx_ready = 1'b1;
                    stall = 0;
                end
            end
            default: tx_ready = 1'b0;
        endcase
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    logic [31:0] model_regs [0:3];
    int          model_err;
    logic [7:0]  exp_tx[$];
    acc_t        exp_acc[$];
    int          tx_rd = 0;
    int          acc_rd = 0;

    task automatic model_packet(input logic [7:0] hdr, input logic [31:0] data);
        logic       wr  = hdr[7];
        logic [4:0] src = hdr[6:2];
        logic [1:0] idx = hdr[1:0];
        logic       bad = (idx == 2'd3);
        logic [31:0] val;
        if (!bad) exp_acc.push_back({BASE + 32'(idx) * 4, wr, wr ? data : 32'h0});
        else if (model_err < 255) model_err++;
        if (!wr) begin
            exp_tx.push_back({1'b1, src, bad, 1'b0});
            val = bad ? 32'h0 : model_regs[idx];
            for (int i = 0; i < 4; i++) exp_tx.push_back(8'(val >> (24 - 8 * i)));
        end else begin
            if (!bad) model_regs[idx] = data;
            if (ACK) exp_tx.push_back({1'b1, src, bad, 1'b1});
        end
    endtask

    // ---------------- drivers ----------------
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n = 0;
        @(negedge clk);
        if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            errors++;
            checks++;
            $display("FAIL rx_timeout: rx_ready=%b, required 1 within 200 cycles", rx_ready);
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic send_packet(input logic [7:0] hdr, input logic [31:0] data, input bit gaps);
        model_packet(hdr, data);
        send_byte(hdr, gaps);
        if (hdr[7]) for (int i = 0; i < 4; i++) send_byte(8'(data >> (24 - 8 * i)), gaps);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy || tx_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            errors++;
            checks++;
            $display("FAIL idle_timeout: busy=%b tx_valid=%b, required both 0", busy, tx_valid);
        end
    endtask

    task automatic check_expect(input string name);
        logic [7:0] b;
        acc_t e;
        acc_t a;
        while (exp_tx.size() > 0) begin
            b = exp_tx.pop_front();
            checks++;
            if (tx_rd >= tx_q.size()) begin
                errors++;
                $display("FAIL %s tx_missing: got nothing, required 0x%02h", name, b);
            end else if (tx_q[tx_rd] !== b) begin
                errors++;
                $display("FAIL %s tx_byte: got 0x%02h, required 0x%02h", name, tx_q[tx_rd], b);
            end
            tx_rd++;
        end
        checks++;
        if (tx_q.size() > tx_rd) begin
            errors++;
            $display("FAIL %s tx_extra: got %0d bytes, required %0d", name, tx_q.size(), tx_rd);
            tx_rd = tx_q.size();
        end
        while (exp_acc.size() > 0) begin
            e = exp_acc.pop_front();
            checks++;
            if (acc_rd >= acc_q.size()) begin
                errors++;
                $display("FAIL %s acc_missing: got none, required addr=0x%08h rw=%b", name, e.addr, e.rw);
            end else begin
                a = acc_q[acc_rd];
                if (a.addr !== e.addr || a.rw !== e.rw || (e.rw && a.data !== e.data)) begin
                    errors++;
                    $display("FAIL %s acc: got addr=0x%08h rw=%b data=0x%08h, required addr=0x%08h rw=%b data=0x%08h",
                             name, a.addr, a.rw, a.data, e.addr, e.rw, e.data);
                end
            end
            acc_rd++;
        end
        checks++;
        if (acc_q.size() > acc_rd) begin
            errors++;
            $display("FAIL %s acc_extra: got %0d accesses, required %0d", name, acc_q.size(), acc_rd);
            acc_rd = acc_q.size();
        end
        checks++;
        if (err_cnt !== 8'(model_err)) begin
            errors++;
            $display("FAIL %s err_cnt: got %0d, required %0d", name, err_cnt, model_err);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({tx_valid, tx_data, bus_Sel, bus_RW, busy} !== 12'h0) begin
            errors++;
            $display("FAIL reset_ctrl: got tx_valid=%b tx_data=0x%02h sel=%b rw=%b busy=%b, required all 0",
                     tx_valid, tx_data, bus_Sel, bus_RW, busy);
        end
        checks++;
        if ({bus_addr, bus_data_wr, err_cnt} !== 72'h0) begin
            errors++;
            $display("FAIL reset_bus: got addr=0x%08h wr=0x%08h err=%0d, required 0",
                     bus_addr, bus_data_wr, err_cnt);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_rx_ready: got %b, required 1", rx_ready);
        end
        for (int i = 0; i < 4; i++) model_regs[i] = 32'h0;
        model_err = 0;
    endtask

    task automatic test_write_gpoly();
        model_packet(8'h8D, 32'h04C1_1DB7);
        send_byte(8'h8D, 1'b0);
        send_byte(8'h04, 1'b0);
        send_byte(8'hC1, 1'b0);
        send_byte(8'h1D, 1'b0);
        send_byte(8'hB7, 1'b0);
        @(negedge clk);
        checks++;
        if ({bus_Sel, bus_RW, bus_addr, bus_data_wr} !== {2'b11, 32'h4003_2004, 32'h04C1_1DB7}) begin
            errors++;
            $display("FAIL wr_latency: got sel=%b rw=%b addr=0x%08h data=0x%08h, required 1 1 0x40032004 0x04c11db7",
                     bus_Sel, bus_RW, bus_addr, bus_data_wr);
        end
        @(negedge clk);
        checks++;
        if ({bus_Sel, bus_RW, bus_addr} !== {2'b00, 32'h4003_2004}) begin
            errors++;
            $display("FAIL wr_after: got sel=%b rw=%b addr=0x%08h, required 0 0 0x40032004",
                     bus_Sel, bus_RW, bus_addr);
        end
        wait_idle();
        check_expect("write_gpoly");
    endtask

    task automatic test_read_ctrl();
        send_packet(8'h82, 32'h2500_0000, 1'b0);
        wait_idle();
        check_expect("write_ctrl");
        model_packet(8'h16, 32'h0);
        send_byte(8'h16, 1'b0);
        @(negedge clk);
        checks++;
        if ({bus_Sel, bus_RW, bus_addr} !== {2'b10, 32'h4003_2008}) begin
            errors++;
            $display("FAIL rd_latency: got sel=%b rw=%b addr=0x%08h, required 1 0 0x40032008",
                     bus_Sel, bus_RW, bus_addr);
        end
        @(negedge clk);
        checks++;
        if ({tx_valid, tx_data} !== {1'b1, 8'h94}) begin
            errors++;
            $display("FAIL rd_hdr_latency: got tx_valid=%b tx_data=0x%02h, required 1 0x94",
                     tx_valid, tx_data);
        end
        wait_idle();
        check_expect("read_ctrl");
    endtask

    task automatic test_invalid();
        send_packet(8'h03, 32'h0, 1'b0);
        wait_idle();
        check_expect("invalid_read");
        for (int i = 0; i < 255; i++) begin
            send_packet({1'($urandom_range(0, 1)), 5'($urandom), 2'b11}, $urandom, 1'b0);
            wait_idle();
        end
        check_expect("invalid_saturate");
        checks++;
        if (err_cnt !== 8'hFF) begin
            errors++;
            $display("FAIL err_saturate: got 0x%02h, required 0xff", err_cnt);
        end
    endtask

    task automatic test_backpressure();
        int stab_bad = 0;
        int rxr_bad  = 0;
        int stalls   = 0;
        int n        = 0;
        logic       prev_v  = 1'b0;
        logic       prev_hs = 1'b0;
        logic [7:0] prev_d  = 8'h00;
        rdy_mode = 2;
        send_packet(8'h05, 32'h0, 1'b0);
        @(negedge clk);
        while (busy && n < 200) begin
            if (prev_v && !prev_hs && (!tx_valid || tx_data !== prev_d)) stab_bad++;
            if (rx_ready) rxr_bad++;
            if (tx_valid && !tx_ready) stalls++;
            prev_v  = tx_valid;
            prev_d  = tx_data;
            prev_hs = tx_valid && tx_ready;
            @(negedge clk);
            n++;
        end
        rdy_mode = 0;
        checks++;
        if (stab_bad !== 0) begin
            errors++;
            $display("FAIL bp_stable: got %0d unstable cycles, required 0", stab_bad);
        end
        checks++;
        if (rxr_bad !== 0) begin
            errors++;
            $display("FAIL bp_rx_ready: got %0d cycles with rx_ready=1, required 0", rxr_bad);
        end
        checks++;
        if (stalls !== 25) begin
            errors++;
            $display("FAIL bp_stalls: got %0d stalled cycles, required 25", stalls);
        end
        wait_idle();
        check_expect("backpressure");
    endtask

    task automatic test_reset_mid_packet();
        send_byte(8'h81, 1'b0);
        send_byte(8'hAA, 1'b0);
        rst = 1'b0;
        #2;
        checks++;
        if ({busy, bus_Sel, err_cnt} !== 10'h0) begin
            errors++;
            $display("FAIL rst_mid_pkt: got busy=%b sel=%b err=%0d, required 0", busy, bus_Sel, err_cnt);
        end
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_err = 0;
        send_packet(8'h80, 32'h1122_3344, 1'b0);
        wait_idle();
        check_expect("reset_mid_packet");

        // abort a response that is stalled on its header byte
        rdy_mode = 3;
        send_byte(8'h01, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (tx_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_resp_pre: got tx_valid=%b, required 1", tx_valid);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if ({tx_valid, tx_data, busy, bus_Sel} !== 11'h0) begin
            errors++;
            $display("FAIL rst_mid_resp: got tx_valid=%b tx_data=0x%02h busy=%b sel=%b, required 0",
                     tx_valid, tx_data, busy, bus_Sel);
        end
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        rdy_mode = 0;
        acc_rd = acc_q.size();   // the aborted read did reach the bus
        repeat (3) @(negedge clk);
        checks++;
        if (tx_q.size() !== tx_rd) begin
            errors++;
            $display("FAIL rst_resp_dropped: got %0d tx bytes, required %0d", tx_q.size(), tx_rd);
        end
    endtask

    task automatic test_random();
        rdy_mode = 1;
        for (int i = 0; i < 40; i++) begin
            send_packet(8'($urandom), $urandom, 1'b1);
            wait_idle();
            check_expect("random");
        end
        rdy_mode = 0;
        checks++;
        if (rw_glitch !== 0) begin
            errors++;
            $display("FAIL rw_without_sel: got %0d cycles, required 0", rw_glitch);
        end
    endtask

    initial begin
        test_reset();
        test_write_gpoly();
        test_read_ctrl();
        test_invalid();
        test_backpressure();
        test_reset_mid_packet();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
